regfile_dump: RTL and testbench
===============================

REGFILE_DUMP -- requirements
Module: regfile_dump

Interface
REQ-001 Parameters SHALL be, one per line (name, default, meaning):
  NUM_REGS  32  architectural registers.
  XLEN  32  register data width.
REQ-002 Ports SHALL be, one per line (name  direction  width  meaning):
  clk  in  1  single clock, rising edge.
  rst_n  in  1  reset, asynchronous and active-low.
  start  in  1  one-cycle request to begin a dump.
  first_idx  in  5  first register index to dump.
  count  in  6  registers to dump, 1..32; 0 means 32.
  rd_addr  out  5  read address to the register-file read port.
  rd_data  in  XLEN  combinational read data for rd_addr.
  out_valid  out  1  out_data/out_idx/out_last valid.
  out_ready  in  1  downstream accepts the current word.
  out_data  out  XLEN  dumped register value.
  out_idx  out  5  index of out_data.
  out_last  out  1  final word of the dump.
  busy  out  1  dump in progress.
  done  out  1  one-cycle pulse after the last word is accepted.

Function
REQ-003 The FSM SHALL have states IDLE, READ, SEND, DONE.
REQ-004 In IDLE, when start=1, the block SHALL latch idx=first_idx and remaining=(count==0 ? 32 : count), then go to READ.
REQ-005 Start SHALL be ignored in every state except IDLE.
REQ-006 In READ (one cycle), rd_addr SHALL equal idx; rd_data SHALL be registered into out_data, with out_idx=idx and out_last=(remaining==1); the FSM SHALL then go to SEND.
REQ-007 When idx==0, out_data SHALL be forced to 0 regardless of rd_data.
REQ-008 In SEND, out_valid SHALL be 1, and out_data, out_idx and out_last SHALL hold stable until out_valid and out_ready are both 1.
REQ-009 On a SEND handshake with remaining>1, the block SHALL set idx=(idx+1) mod 32 and remaining-=1, then go to READ.
REQ-010 On a SEND handshake with remaining==1, the FSM SHALL go to DONE.
REQ-011 DONE SHALL last one cycle, assert done=1, then return to IDLE; a start in the DONE cycle SHALL be ignored.
REQ-012 Index wrap-around from 31 SHALL go to 0, which is then dumped as 0 per REQ-007.
REQ-013 busy SHALL be 1 in READ, SEND and DONE, and 0 in IDLE.
REQ-014 rd_addr SHALL be 0 in every state except READ.
REQ-015 out_valid SHALL be 0 outside SEND.
REQ-016 Throughput SHALL be one word per two cycles with out_ready held at 1.
REQ-017 Latency from the start cycle to the first out_valid SHALL be 2 cycles.
REQ-018 out_ready asserted while out_valid=0 SHALL have no effect.

Reset
REQ-019 rst_n=0 SHALL asynchronously force state=IDLE, idx=0, remaining=0, out_valid=0, out_data=0, out_idx=0, out_last=0, busy=0, done=0 and rd_addr=0.
REQ-020 Reset asserted mid-dump SHALL abort the dump with no done pulse; after release the block SHALL wait in IDLE for a new start.

Structure
REQ-021 A shared package regfile_pkg SHALL hold REG_ADDR_W=5, XLEN=32, NUM_REGS=32 and the dump_state_t enum (IDLE, READ, SEND, DONE).
REQ-022 The block SHALL contain no sub-modules; the FSM, counters and output register SHALL live in regfile_dump.
REQ-023 rd_addr/rd_data SHALL connect to a spare read port of register_file without modifying it.

Verification
REQ-024 Full dump: the bench SHALL preload x1..x31=0x100+i, then pulse start with first_idx=0, count=0 and out_ready=1 -> 32 words with idx 0..31, data 0, 0x101..0x11F, out_last on idx 31, done 1 cycle after.
REQ-025 Wrap: first_idx=30, count=4 -> words in order idx 30, 31, 0, 1 with data 0x11E, 0x11F, 0, 0x101.
REQ-026 Backpressure: out_ready low for 5 cycles on the 2nd word of count=3 -> out_data/out_idx held stable, no word lost or duplicated, done after the 3rd handshake.
REQ-027 Start while busy: pulse start again during SEND -> ignored, word count unchanged.
REQ-028 Reset mid-dump: drive rst_n low during SEND of word 2 -> all outputs 0 immediately, no done pulse; a fresh start afterwards completes normally.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared definitions for the register-file dump engine: address/data widths
// and the dump sequencer state encoding.
package regfile_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int XLEN       = 32;
    localparam int NUM_REGS   = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        SEND = 2'd2,
        DONE = 2'd3
    } dump_state_t;

endpackage

// File: rtl/regfile_dump.sv
// Streams a contiguous (wrapping) range of architectural registers out of a
// spare register-file read port as a valid/ready word stream.
module regfile_dump
    import regfile_pkg::*;
#(
    parameter int NUM_REGS = 32,
    parameter int XLEN     = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [4:0]            first_idx,
    input  logic [5:0]            count,
    output logic [4:0]            rd_addr,
    input  logic [XLEN-1:0]       rd_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [XLEN-1:0]       out_data,
    output logic [4:0]            out_idx,
    output logic                  out_last,
    output logic                  busy,
    output logic                  done
);

    dump_state_t           state_q, state_d;
    logic [REG_ADDR_W-1:0] idx_q, idx_d;
    logic [5:0]            rem_q, rem_d;
    logic [XLEN-1:0]       out_data_q, out_data_d;
    logic [REG_ADDR_W-1:0] out_idx_q, out_idx_d;
    logic                  out_last_q, out_last_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q      <= '0;
            rem_q      <= '0;
            out_data_q <= '0;
            out_idx_q  <= '0;
            out_last_q <= 1'b0;
        end else begin
            idx_q      <= idx_d;
            rem_q      <= rem_d;
            out_data_q <= out_data_d;
            out_idx_q  <= out_idx_d;
            out_last_q <= out_last_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        rem_d      = rem_q;
        out_data_d = out_data_q;
        out_idx_d  = out_idx_q;
        out_last_d = out_last_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    idx_d   = first_idx;
                    rem_d   = (count == 6'd0) ? 6'(NUM_REGS) : count;
                    state_d = READ;
                end
            end
            READ: begin
                // x0 is hard-wired zero regardless of what the port returns
                out_data_d = (idx_q == '0) ? '0 : rd_data;
                out_idx_d  = idx_q;
                out_last_d = (rem_q == 6'd1);
                state_d    = SEND;
            end
            SEND: begin
                if (out_ready) begin
                    if (rem_q > 6'd1) begin
                        idx_d   = idx_q + 1'b1;
                        rem_d   = rem_q - 6'd1;
                        state_d = READ;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        out_valid = (state_q == SEND);
        busy      = (state_q != IDLE);
        done      = (state_q == DONE);
        rd_addr   = (state_q == READ) ? idx_q : '0;
        out_data  = out_data_q;
        out_idx   = out_idx_q;
        out_last  = out_last_q;
    end

endmodule

// File: tb/tb_regfile_dump.sv
// Directed bench for regfile_dump: table of dump ranges plus hand-written
// backpressure, start-while-busy, start-in-DONE and reset-abort sequences.
module tb_regfile_dump;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [4:0]  first_idx;
    logic [5:0]  count;
    logic [4:0]  rd_addr;
    logic [31:0] rd_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [4:0]  out_idx;
    logic        out_last;
    logic        busy;
    logic        done;

    logic [31:0] rf [32];
    assign rd_data = rf[rd_addr];

    always #5 clk = ~clk;

    regfile_dump #(.NUM_REGS(32), .XLEN(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .first_idx (first_idx),
        .count     (count),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_idx   (out_idx),
        .out_last  (out_last),
        .busy      (busy),
        .done      (done)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] exp_data(input logic [4:0] idx);
        return (idx == 5'd0) ? 32'd0 : (32'h100 + 32'(idx));
    endfunction

    // expectation state shared with the monitor
    logic [4:0]  exp_first;
    int          exp_n;
    int          cap_n;
    int          done_n;
    int          stall_cnt;
    int          cyc = 0;
    int          hs_first_cyc;
    int          hs_last_cyc;
    logic [4:0]  last_idx_cap;
    logic [31:0] last_data_cap;
    logic        exp_done_next;
    logic        stall_pend;
    logic [31:0] held_data;
    logic [4:0]  held_idx;
    logic        held_last;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rst_n) begin
            logic [4:0] e_idx;
            if (out_valid) chk("busy_with_valid", busy, 1);
            if (stall_pend) begin
                chk("hold_data", out_data, held_data);
                chk("hold_idx", out_idx, held_idx);
                chk("hold_last", out_last, held_last);
                stall_pend = 1'b0;
            end
            if (out_valid && !out_ready) begin
                stall_pend = 1'b1;
                held_data  = out_data;
                held_idx   = out_idx;
                held_last  = out_last;
                stall_cnt++;
            end
            if (exp_done_next) begin
                chk("done_after_last", done, 1);
                exp_done_next = 1'b0;
            end
            if (done) done_n++;
            if (out_valid && out_ready) begin
                $display("word %0d idx=%0d data=%h last=%0b", cap_n, out_idx, out_data, out_last);
                if (cap_n >= exp_n) begin
                    chk("extra_word", 32'(cap_n + 1), 32'(exp_n));
                end else begin
                    e_idx = exp_first + 5'(cap_n);
                    chk("word_idx", 32'(out_idx), 32'(e_idx));
                    chk("word_data", out_data, exp_data(e_idx));
                    chk("word_last", 32'(out_last), (cap_n == exp_n - 1) ? 32'd1 : 32'd0);
                end
                if (cap_n == 0) hs_first_cyc = cyc;
                hs_last_cyc   = cyc;
                last_idx_cap  = out_idx;
                last_data_cap = out_data;
                if (out_last) exp_done_next = 1'b1;
                cap_n++;
            end
        end
    end

    task automatic start_dump(input logic [4:0] f, input logic [5:0] c);
        exp_first = f;
        exp_n     = (c == 6'd0) ? 32 : int'(c);
        cap_n     = 0;
        done_n    = 0;
        stall_cnt = 0;
        @(posedge clk); #1;
        start = 1'b1; first_idx = f; count = c;
        @(posedge clk); #1;
        start = 1'b0;
        chk("busy_in_read", busy, 1);
        chk("rd_addr_in_read", 32'(rd_addr), 32'(f));
        chk("valid_in_read", out_valid, 0);
        @(posedge clk); #1;
        chk("valid_latency2", out_valid, 1);
    endtask

    task automatic wait_done(input bit poke_in_done);
        bit seen = 0;
        for (int i = 0; i < 400; i++) begin
            @(posedge clk); #1;
            if (done) begin
                seen = 1;
                break;
            end
        end
        chk("done_timeout", 32'(seen), 1);
        if (poke_in_done) begin
            start = 1'b1; first_idx = 5'd7; count = 6'd1;
        end
        @(posedge clk); #1;
        start = 1'b0;
        chk("idle_after_done", busy, 0);
        chk("done_one_cycle", done, 0);
        @(posedge clk); #1;
        chk("still_idle", busy, 0);
        chk("done_pulses", 32'(done_n), 1);
        chk("word_count", 32'(cap_n), 32'(exp_n));
    endtask

    typedef struct {
        logic [4:0]  first;
        logic [5:0]  cnt;
        int          words;
        logic [4:0]  last_idx;
        logic [31:0] last_data;
    } vec_t;

    vec_t vecs [5];

    initial begin
        vecs[0] = '{first: 5'd0,  cnt: 6'd0,  words: 32, last_idx: 5'd31, last_data: 32'h11F};
        vecs[1] = '{first: 5'd30, cnt: 6'd4,  words: 4,  last_idx: 5'd1,  last_data: 32'h101};
        vecs[2] = '{first: 5'd5,  cnt: 6'd1,  words: 1,  last_idx: 5'd5,  last_data: 32'h105};
        vecs[3] = '{first: 5'd31, cnt: 6'd2,  words: 2,  last_idx: 5'd0,  last_data: 32'h0};
        vecs[4] = '{first: 5'd10, cnt: 6'd32, words: 32, last_idx: 5'd9,  last_data: 32'h109};

        rf[0] = 32'hDEADBEEF;  // non-zero so forcing x0 to 0 is observable
        for (int i = 1; i < 32; i++) rf[i] = 32'h100 + i;

        exp_first = '0; exp_n = 0; cap_n = 0; done_n = 0; stall_cnt = 0;
        exp_done_next = 1'b0; stall_pend = 1'b0;
        start = 1'b0; first_idx = '0; count = '0; out_ready = 1'b1;
        rst_n = 1'b0;
        #1;
        chk("rst_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_data", out_data, 0);
        chk("rst_idx", 32'(out_idx), 0);
        chk("rst_last", out_last, 0);
        chk("rst_rd_addr", 32'(rd_addr), 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b1; start = 1'b0;
        chk("no_start_idle", busy, 0);

        for (int v = 0; v < 5; v++) begin
            start_dump(vecs[v].first, vecs[v].cnt);
            wait_done(0);
            chk("tbl_words", 32'(cap_n), 32'(vecs[v].words));
            chk("tbl_last_idx", 32'(last_idx_cap), 32'(vecs[v].last_idx));
            chk("tbl_last_data", last_data_cap, vecs[v].last_data);
            chk("tbl_throughput", 32'(hs_last_cyc - hs_first_cyc), 32'(2 * (vecs[v].words - 1)));
        end

        // backpressure on the second word
        start_dump(5'd8, 6'd3);
        for (int i = 0; i < 50 && cap_n < 1; i++) begin
            @(posedge clk); #1;
        end
        out_ready = 1'b0;
        repeat (6) @(posedge clk);
        #1 out_ready = 1'b1;
        wait_done(0);
        chk("bp_stall_cycles", 32'(stall_cnt), 5);

        // start while busy, then start during the DONE cycle
        start_dump(5'd3, 6'd4);
        start = 1'b1; first_idx = 5'd20; count = 6'd1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(1);

        // reset in the middle of word 2
        start_dump(5'd1, 6'd4);
        for (int i = 0; i < 50 && cap_n < 1; i++) begin
            @(posedge clk); #1;
        end
        out_ready = 1'b0;
        for (int i = 0; i < 50 && !out_valid; i++) begin
            @(posedge clk); #1;
        end
        chk("mid_send_valid", out_valid, 1);
        #1 rst_n = 1'b0;
        #1;
        chk("arst_valid", out_valid, 0);
        chk("arst_busy", busy, 0);
        chk("arst_data", out_data, 0);
        chk("arst_idx", 32'(out_idx), 0);
        chk("arst_last", out_last, 0);
        chk("arst_done", done, 0);
        chk("arst_rd_addr", 32'(rd_addr), 0);
        stall_pend = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        out_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        chk("post_rst_idle", busy, 0);
        chk("post_rst_no_done", 32'(done_n), 0);
        chk("post_rst_words", 32'(cap_n), 1);
        start_dump(5'd2, 6'd3);
        wait_done(0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
